// File: rtl/dcok_monitor.sv
// rtl/dcok_monitor.sv - Q-bus BDCOK receiver: synchronise, de-glitch and classify negations
module dcok_monitor #(
    parameter int FILT_LEN = 3,
    parameter int MIN_LOW  = 8,
    parameter int MAX_LOW  = 2500,
    parameter int INIT_LEN = 250,
    localparam int W       = $clog2(MAX_LOW + 1)
) (
    input  logic         clock,
    input  logic         nrst,
    input  logic         bdcok_in,
    input  logic         ena,
    output logic         init,
    output logic         restart,
    output logic         glitch,
    output logic         dcfail,
    output logic [W-1:0] last_low
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int IW = $clog2(INIT_LEN + 1);

    typedef enum logic [1:0] {S_OK, S_LOW, S_FAIL, S_INIT} state_t;

    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d, filt_prev_q;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          filt_fall;

    state_t        state_q, state_d;
    logic [W-1:0]  lowcnt_q, lowcnt_d;
    logic [IW-1:0] initcnt_q, initcnt_d;
    logic [W-1:0]  last_low_q, last_low_d;
    logic          init_q, init_d;
    logic          dcfail_q, dcfail_d;
    logic          restart_q, restart_d;
    logic          glitch_q, glitch_d;

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
        end else begin
            sync1_q     <= bdcok_in;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            fcnt_q      <= fcnt_d;
        end
    end

    // Any sample agreeing with the filtered level restarts the run count.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync2_q != filt_q) begin
            if (fcnt_q == FW'(FILT_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Edge-based so a negation already in progress when ena rises is ignored.
    assign filt_fall = filt_prev_q & ~filt_q;

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_OK;
            lowcnt_q   <= '0;
            initcnt_q  <= '0;
            last_low_q <= '0;
            init_q     <= 1'b0;
            dcfail_q   <= 1'b0;
            restart_q  <= 1'b0;
            glitch_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lowcnt_q   <= lowcnt_d;
            initcnt_q  <= initcnt_d;
            last_low_q <= last_low_d;
            init_q     <= init_d;
            dcfail_q   <= dcfail_d;
            restart_q  <= restart_d;
            glitch_q   <= glitch_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lowcnt_d   = lowcnt_q;
        initcnt_d  = initcnt_q;
        last_low_d = last_low_q;
        restart_d  = 1'b0;
        glitch_d   = 1'b0;

        case (state_q)
            S_OK: begin
                if (filt_fall) begin
                    state_d  = S_LOW;
                    lowcnt_d = W'(1);
                end
            end
            S_LOW: begin
                if (!filt_q) begin
                    if (lowcnt_q == W'(MAX_LOW - 1)) begin
                        state_d  = S_FAIL;
                        lowcnt_d = W'(MAX_LOW);
                    end else begin
                        lowcnt_d = lowcnt_q + 1'b1;
                    end
                end else if (lowcnt_q < W'(MIN_LOW)) begin
                    glitch_d = 1'b1;
                    state_d  = S_OK;
                    lowcnt_d = '0;
                end else begin
                    restart_d  = 1'b1;
                    last_low_d = lowcnt_q;
                    state_d    = S_INIT;
                    initcnt_d  = '0;
                end
            end
            S_FAIL: begin
                if (filt_q) begin
                    last_low_d = W'(MAX_LOW);
                    restart_d  = 1'b1;
                    state_d    = S_INIT;
                    initcnt_d  = '0;
                end
            end
            S_INIT: begin
                if (filt_fall) begin
                    state_d  = S_LOW;
                    lowcnt_d = W'(1);
                end else if (initcnt_q == IW'(INIT_LEN - 1)) begin
                    state_d = S_OK;
                end else begin
                    initcnt_d = initcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_OK;
            end
        endcase

        if (!ena) begin
            state_d    = S_OK;
            lowcnt_d   = '0;
            initcnt_d  = '0;
            last_low_d = last_low_q;
            restart_d  = 1'b0;
            glitch_d   = 1'b0;
        end

        // Level outputs are decoded from the next state so they track state entry.
        init_d   = (state_d == S_FAIL) || (state_d == S_INIT);
        dcfail_d = (state_d == S_FAIL);
    end

    assign init     = init_q;
    assign restart  = restart_q;
    assign glitch   = glitch_q;
    assign dcfail   = dcfail_q;
    assign last_low = last_low_q;

endmodule

// File: tb/tb_dcok_monitor.sv
// tb/tb_dcok_monitor.sv - randomized negation trains against a timeline model of dcok_monitor
module tb_dcok_monitor;

    localparam int FILT_LEN = 3;
    localparam int MIN_LOW  = 8;
    localparam int MAX_LOW  = 2500;
    localparam int INIT_LEN = 250;
    localparam int W        = $clog2(MAX_LOW + 1);
    localparam int N        = 40000;

    logic         clock = 1'b0;
    logic         nrst;
    logic         bdcok_in;
    logic         ena;
    logic         init, restart, glitch, dcfail;
    logic [W-1:0] last_low;

    dcok_monitor #(
        .FILT_LEN(FILT_LEN), .MIN_LOW(MIN_LOW), .MAX_LOW(MAX_LOW), .INIT_LEN(INIT_LEN)
    ) dut (
        .clock(clock), .nrst(nrst), .bdcok_in(bdcok_in), .ena(ena),
        .init(init), .restart(restart), .glitch(glitch), .dcfail(dcfail),
        .last_low(last_low)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] pack(input bit i, input bit r, input bit g, input bit d,
                                         input int ll);
        return {16'd0, i, r, g, d, ll[11:0]};
    endfunction

    // Stimulus and expected timeline, indexed by the clock edge that samples raw[n].
    bit raw[N];
    bit e_init[N], e_rst[N], e_gl[N], e_dcf[N];
    bit upd[N];
    int upd_val[N];
    int pr[$], pl[$];
    int vf[$], vl[$];
    int init_sel[6] = '{0, 2, 4, 5, 8, 9};

    initial begin
        int n, n_end, sel, len, gap, k, ll, seen, found;

        nrst     = 1'b0;
        ena      = 1'b1;
        bdcok_in = 1'b1;
        repeat (3) step();
        check_eq("reset_outputs", pack(init, restart, glitch, dcfail, int'(last_low)), 32'd0);

        for (int c = 0; c < N; c++) begin
            raw[c] = 1'b1; e_init[c] = 0; e_rst[c] = 0; e_gl[c] = 0; e_dcf[c] = 0;
            upd[c] = 0; upd_val[c] = 0;
        end

        n = 10;
        k = 0;
        while (k < 60) begin
            sel = (k < 6) ? init_sel[k] : $urandom_range(0, 9);
            case (sel)
                0, 1:    len = $urandom_range(1, FILT_LEN - 1);
                2, 3:    len = $urandom_range(FILT_LEN, MIN_LOW - 1);
                4:       len = $urandom_range(MIN_LOW - 1, MIN_LOW);
                5, 6, 7: len = $urandom_range(MIN_LOW + 1, 60);
                8:       len = $urandom_range(MAX_LOW - 2, MAX_LOW + 1);
                default: len = 3000;
            endcase
            gap = ($urandom_range(0, 2) == 0) ? $urandom_range(260, 400)
                                              : $urandom_range(FILT_LEN, 120);
            if (n + len + gap + 600 > N) break;
            pr.push_back(n);
            pl.push_back(len);
            for (int c = n; c < n + len; c++) raw[c] = 1'b0;
            n += len + gap;
            k++;
        end
        n_end = n + 300;

        // Filtered negations: lows shorter than FILT_LEN vanish, the rest keep their length
        // and appear FILT_LEN+1 edges later.
        for (int i = 0; i < pr.size(); i++) begin
            if (pl[i] >= FILT_LEN) begin
                vf.push_back(pr[i] + FILT_LEN + 1);
                vl.push_back(pl[i]);
            end
        end

        for (int i = 0; i < vf.size(); i++) begin
            int f, L, t, nf, iend;
            f  = vf[i];
            L  = vl[i];
            t  = f + L + 1;
            nf = (i + 1 < vf.size()) ? vf[i + 1] : N;
            if (L < MIN_LOW) begin
                e_gl[t] = 1;
            end else begin
                e_rst[t]   = 1;
                upd[t]     = 1;
                upd_val[t] = (L >= MAX_LOW) ? MAX_LOW : L;
                if (L >= MAX_LOW) begin
                    for (int c = f + MAX_LOW; c < t; c++) begin
                        e_dcf[c]  = 1;
                        e_init[c] = 1;
                    end
                end
                iend = (t + INIT_LEN < nf + 1) ? t + INIT_LEN : nf + 1;
                for (int c = t; c < iend; c++) e_init[c] = 1;
            end
        end

        nrst = 1'b1;
        ll = 0;
        for (int c = 0; c < n_end; c++) begin
            bdcok_in = raw[c];
            step();
            if (upd[c]) ll = upd_val[c];
            check_eq($sformatf("cycle%0d", c),
                     pack(init, restart, glitch, dcfail, int'(last_low)),
                     pack(e_init[c], e_rst[c], e_gl[c], e_dcf[c], ll));
        end

        // Restart, then ena drop during init.
        bdcok_in = 1'b0;
        repeat (10) step();
        bdcok_in = 1'b1;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (restart) found = 1;
        end
        check_eq("restart_seen", found, 1);
        check_eq("last_low_10", int'(last_low), 10);
        repeat (20) step();
        check_eq("init_mid", init, 1'b1);
        ena = 1'b0;
        step();
        check_eq("ena_off_outputs", pack(init, restart, glitch, dcfail, int'(last_low)),
                 pack(0, 0, 0, 0, 10));

        // Negation already low when ena rises must go unmeasured.
        bdcok_in = 1'b0;
        repeat (20) step();
        ena = 1'b1;
        repeat (10) step();
        bdcok_in = 1'b1;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            seen |= int'(init | restart | glitch | dcfail);
        end
        check_eq("no_measure_after_ena", seen, 0);
        check_eq("last_low_held", int'(last_low), 10);

        // Long negation into DC fail, then async reset.
        bdcok_in = 1'b0;
        found = 0;
        for (int c = 0; c < 2600 && !found; c++) begin
            step();
            if (dcfail) found = 1;
        end
        check_eq("dcfail_seen", found, 1);
        check_eq("fail_init", init, 1'b1);
        #2;
        nrst = 1'b0;
        #1;
        check_eq("async_reset", pack(init, restart, glitch, dcfail, int'(last_low)), 32'd0);
        #3;
        bdcok_in = 1'b1;
        repeat (2) step();
        nrst = 1'b1;
        repeat (10) step();
        check_eq("after_reset_idle", pack(init, restart, glitch, dcfail, int'(last_low)), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
